// File: rtl/batrider_wrbuf_pkg.sv
// Shared types and constants for the batrider download write buffer.
package batrider_wrbuf_pkg;

  localparam int WRBUF_AW = 22;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // DQM polarity: a set bit suppresses that byte lane.
  localparam logic [1:0] MASK_HI   = 2'b01;
  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_BOTH = 2'b00;

  typedef struct packed {
    logic [WRBUF_AW-1:0] addr;
    logic [1:0]          ba;
    logic [15:0]         data;
    logic [1:0]          mask;
  } wr_entry_t;

  function automatic logic [15:0] lane_data(input logic odd, input logic [7:0] b);
    return odd ? {8'h00, b} : {b, 8'h00};
  endfunction

endpackage

// File: rtl/batrider_wrbuf_fifo.sv
// Small synchronous FIFO of word-write entries; pointers carry one extra
// wrap bit so full and empty are distinguished without a separate flag.
module batrider_wrbuf_fifo
  import batrider_wrbuf_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  wr_entry_t                push_data_i,
  input  logic                     pop_i,
  output wr_entry_t                head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);

  wr_entry_t       mem_q [DEPTH];
  logic [PW:0]     wrPtr_q;
  logic [PW:0]     rdPtr_q;
  logic            doPush;
  logic            doPop;

  assign count_o = wrPtr_q - rdPtr_q;
  assign full_o  = (count_o == (PW+1)'(DEPTH));
  assign empty_o = (count_o == '0);
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  assign head_o  = mem_q[rdPtr_q[PW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q[PW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/batrider_prog_wrbuf.sv
// Byte-to-word write buffer feeding the SDRAM programming port.
// Optional BATRIDER_WRBUF_CHKSUM_EN adds CHKSUM and WR_COUNT outputs.
module batrider_prog_wrbuf
  import batrider_wrbuf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = WRBUF_AW
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          DOWNLOADING,
  input  logic          IN_WE,
  input  logic [AW:0]   IN_ADDR,
  input  logic [1:0]    IN_BA,
  input  logic [7:0]    IN_DATA,
  output logic          WAIT,
  output logic [AW-1:0] PROG_ADDR,
  output logic [15:0]   PROG_DATA,
  output logic [1:0]    PROG_MASK,
  output logic [1:0]    PROG_BA,
  output logic          PROG_WE,
  input  logic          PROG_RDY
`ifdef BATRIDER_WRBUF_CHKSUM_EN
  ,
  output logic [15:0]   CHKSUM,
  output logic [23:0]   WR_COUNT
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]   fifoCount;
  logic          fifoFull;
  logic          fifoEmpty;
  logic          fifoPop;
  wr_entry_t     fifoHead;

  logic          pendValid_q, pendValid_d;
  logic [AW-1:0] pendAddr_q,  pendAddr_d;
  logic [1:0]    pendBa_q,    pendBa_d;
  logic [15:0]   pendData_q,  pendData_d;
  logic [1:0]    pendMask_q,  pendMask_d;
  logic          pushValid_q, pushValid_d;
  wr_entry_t     pushEntry_q, pushEntry_d;
  logic          flushPend_q, flushPend_d;
  logic          dlPrev_q;

  logic [1:0]    state_q,    state_d;
  logic [AW-1:0] progAddr_q, progAddr_d;
  logic [15:0]   progData_q, progData_d;
  logic [1:0]    progMask_q, progMask_d;
  logic [1:0]    progBa_q,   progBa_d;
  logic          progWe_q,   progWe_d;

  logic          accept;
  logic [AW-1:0] inWord;
  logic          inOdd;
  logic [1:0]    inMask;
  logic [15:0]   inData;
  logic          canMerge;
  wr_entry_t     pendEntry;

  // The reserved slot covers the one push that may already be in flight.
  assign WAIT   = (fifoCount >= (PW+1)'(DEPTH-1));
  assign accept = IN_WE & ~WAIT;
  assign inWord = IN_ADDR[AW:1];
  assign inOdd  = IN_ADDR[0];
  assign inMask = inOdd ? MASK_LO : MASK_HI;
  assign inData = lane_data(inOdd, IN_DATA);

  assign canMerge = pendValid_q && (pendAddr_q == inWord) && (pendBa_q == IN_BA) &&
                    (((pendMask_q == MASK_HI) && inOdd) || ((pendMask_q == MASK_LO) && !inOdd));

  assign pendEntry = '{addr: WRBUF_AW'(pendAddr_q), ba: pendBa_q,
                       data: pendData_q, mask: pendMask_q};

  always_comb begin
    pendValid_d = pendValid_q;
    pendAddr_d  = pendAddr_q;
    pendBa_d    = pendBa_q;
    pendData_d  = pendData_q;
    pendMask_d  = pendMask_q;
    pushValid_d = 1'b0;
    pushEntry_d = pushEntry_q;
    flushPend_d = flushPend_q | (dlPrev_q & ~DOWNLOADING);
    if (accept) begin
      if (canMerge) begin
        pushValid_d = 1'b1;
        pushEntry_d = '{addr: WRBUF_AW'(pendAddr_q), ba: pendBa_q,
                        data: pendData_q | inData, mask: MASK_BOTH};
        pendValid_d = 1'b0;
      end else begin
        if (pendValid_q) begin
          pushValid_d = 1'b1;
          pushEntry_d = pendEntry;
        end
        pendValid_d = 1'b1;
        pendAddr_d  = inWord;
        pendBa_d    = IN_BA;
        pendData_d  = inData;
        pendMask_d  = inMask;
      end
    end else if (flushPend_q) begin
      if (!pendValid_q) begin
        flushPend_d = 1'b0;
      end else if (!pushValid_q && !fifoFull) begin
        pushValid_d = 1'b1;
        pushEntry_d = pendEntry;
        pendValid_d = 1'b0;
        flushPend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pendValid_q <= 1'b0;
      pendAddr_q  <= '0;
      pendBa_q    <= '0;
      pendData_q  <= '0;
      pendMask_q  <= '0;
      pushValid_q <= 1'b0;
      pushEntry_q <= '0;
      flushPend_q <= 1'b0;
      dlPrev_q    <= 1'b0;
    end else begin
      pendValid_q <= pendValid_d;
      pendAddr_q  <= pendAddr_d;
      pendBa_q    <= pendBa_d;
      pendData_q  <= pendData_d;
      pendMask_q  <= pendMask_d;
      pushValid_q <= pushValid_d;
      pushEntry_q <= pushEntry_d;
      flushPend_q <= flushPend_d;
      dlPrev_q    <= DOWNLOADING;
    end
  end

  batrider_wrbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (CLK),
    .rst_ni      (RESET_N),
    .push_i      (pushValid_q),
    .push_data_i (pushEntry_q),
    .pop_i       (fifoPop),
    .head_o      (fifoHead),
    .count_o     (fifoCount),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty)
  );

  // The head stays queued during WRITE and is popped only on completion.
  always_comb begin
    state_d    = state_q;
    progAddr_d = progAddr_q;
    progData_d = progData_q;
    progMask_d = progMask_q;
    progBa_d   = progBa_q;
    progWe_d   = progWe_q;
    fifoPop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifoEmpty) begin
          progAddr_d = fifoHead.addr[AW-1:0];
          progData_d = fifoHead.data;
          progMask_d = fifoHead.mask;
          progBa_d   = fifoHead.ba;
          progWe_d   = 1'b1;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (PROG_RDY) begin
          fifoPop  = 1'b1;
          progWe_d = 1'b0;
          state_d  = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      progAddr_q <= '0;
      progData_q <= '0;
      progMask_q <= '0;
      progBa_q   <= '0;
      progWe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      progAddr_q <= progAddr_d;
      progData_q <= progData_d;
      progMask_q <= progMask_d;
      progBa_q   <= progBa_d;
      progWe_q   <= progWe_d;
    end
  end

  assign PROG_ADDR = progAddr_q;
  assign PROG_DATA = progData_q;
  assign PROG_MASK = progMask_q;
  assign PROG_BA   = progBa_q;
  assign PROG_WE   = progWe_q;

`ifdef BATRIDER_WRBUF_CHKSUM_EN
  logic [15:0] chksum_q;
  logic [23:0] wrCount_q;
  logic        dlRise;

  assign dlRise = DOWNLOADING & ~dlPrev_q;

  // A byte landing on the start edge is the first byte of the new download.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      chksum_q  <= '0;
      wrCount_q <= '0;
    end else begin
      if (dlRise)      chksum_q <= accept ? {8'h00, IN_DATA} : 16'h0000;
      else if (accept) chksum_q <= chksum_q + {8'h00, IN_DATA};
      if (dlRise)       wrCount_q <= fifoPop ? 24'd1 : 24'd0;
      else if (fifoPop) wrCount_q <= wrCount_q + 24'd1;
    end
  end

  assign CHKSUM   = chksum_q;
  assign WR_COUNT = wrCount_q;
`endif

endmodule

// File: tb/tb_batrider_prog_wrbuf.sv
// Directed bench for batrider_prog_wrbuf: merging, flush, back-pressure,
// RDY handling and async reset (checksum outputs when enabled).
module tb_batrider_prog_wrbuf;

  typedef struct packed {
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
    logic [1:0]  ba;
  } wr_t;

  logic        CLK;
  logic        RESET_N;
  logic        DOWNLOADING;
  logic        IN_WE;
  logic [22:0] IN_ADDR;
  logic [1:0]  IN_BA;
  logic [7:0]  IN_DATA;
  logic        WAIT;
  logic [21:0] PROG_ADDR;
  logic [15:0] PROG_DATA;
  logic [1:0]  PROG_MASK;
  logic [1:0]  PROG_BA;
  logic        PROG_WE;
  logic        PROG_RDY;
`ifdef BATRIDER_WRBUF_CHKSUM_EN
  logic [15:0] CHKSUM;
  logic [23:0] WR_COUNT;
`endif

  int  checks = 0;
  int  errors = 0;
  wr_t wrQ[$];

  batrider_prog_wrbuf #(.DEPTH(8), .AW(22)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .DOWNLOADING (DOWNLOADING),
    .IN_WE       (IN_WE),
    .IN_ADDR     (IN_ADDR),
    .IN_BA       (IN_BA),
    .IN_DATA     (IN_DATA),
    .WAIT        (WAIT),
    .PROG_ADDR   (PROG_ADDR),
    .PROG_DATA   (PROG_DATA),
    .PROG_MASK   (PROG_MASK),
    .PROG_BA     (PROG_BA),
    .PROG_WE     (PROG_WE),
    .PROG_RDY    (PROG_RDY)
`ifdef BATRIDER_WRBUF_CHKSUM_EN
    ,
    .CHKSUM      (CHKSUM),
    .WR_COUNT    (WR_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Record every completed handshake half a cycle before the edge that completes it.
  always @(negedge CLK) begin
    if (RESET_N && PROG_WE && PROG_RDY)
      wrQ.push_back('{addr: PROG_ADDR, data: PROG_DATA, mask: PROG_MASK, ba: PROG_BA});
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic sendByte(input logic [22:0] a, input logic [1:0] ba, input logic [7:0] d);
    int k = 0;
    while (WAIT && k < 300) begin
      tick;
      k++;
    end
    if (WAIT) begin
      checks++; errors++;
      $display("[TB] FAIL send_wait_timeout: WAIT=%0b after %0d cycles, required 0", WAIT, k);
    end
    IN_WE = 1'b1; IN_ADDR = a; IN_BA = ba; IN_DATA = d;
    tick;
    IN_WE = 1'b0;
  endtask

  task automatic waitWrites(input int n);
    int k = 0;
    while (wrQ.size() < n && k < 400) begin
      tick;
      k++;
    end
    checks++;
    if (wrQ.size() < n) begin
      errors++;
      $display("[TB] FAIL write_timeout: got %0d writes, required %0d", wrQ.size(), n);
    end
  endtask

  task automatic waitWe(input string name);
    int k = 0;
    while (!PROG_WE && k < 100) begin
      tick;
      k++;
    end
    checks++;
    if (PROG_WE !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s: PROG_WE=%b, required 1", name, PROG_WE);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({PROG_WE, WAIT, PROG_MASK, PROG_BA} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: WE=%b WAIT=%b MASK=%b BA=%b, required all 0",
               PROG_WE, WAIT, PROG_MASK, PROG_BA);
    end
    checks++;
    if ({PROG_ADDR, PROG_DATA} !== 38'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: ADDR=%h DATA=%h, required 0", PROG_ADDR, PROG_DATA);
    end
`ifdef BATRIDER_WRBUF_CHKSUM_EN
    checks++;
    if ({CHKSUM, WR_COUNT} !== 40'h0) begin
      errors++;
      $display("[TB] FAIL reset_chksum: CHKSUM=%h WR_COUNT=%h, required 0", CHKSUM, WR_COUNT);
    end
`endif
  endtask

  task automatic test_merge;
    wrQ.delete();
    PROG_RDY = 1'b1;
    sendByte(23'h000, 2'd0, 8'h12);
    sendByte(23'h001, 2'd0, 8'h34);
    checks++;
    if (PROG_WE !== 1'b0) begin
      errors++; $display("[TB] FAIL merge_lat_push: PROG_WE=%b, required 0", PROG_WE);
    end
    tick;
    checks++;
    if (PROG_WE !== 1'b0) begin
      errors++; $display("[TB] FAIL merge_lat_latch: PROG_WE=%b, required 0", PROG_WE);
    end
    tick;
    checks++;
    if (PROG_WE !== 1'b1) begin
      errors++; $display("[TB] FAIL merge_lat_we: PROG_WE=%b, required 1", PROG_WE);
    end
    waitWrites(1);
    repeat (6) tick;
    checks++;
    if (wrQ.size() != 1 || wrQ[0] !== wr_t'{22'h0, 16'h1234, 2'b00, 2'd0}) begin
      errors++;
      $display("[TB] FAIL merge_write: count=%0d first=%h, required count=1 %h", wrQ.size(),
               wrQ.size() > 0 ? wrQ[0] : wr_t'('0), wr_t'{22'h0, 16'h1234, 2'b00, 2'd0});
    end
  endtask

  task automatic test_flush;
    wrQ.delete();
    sendByte(23'h005, 2'd2, 8'hAB);
    repeat (6) tick;
    checks++;
    if (wrQ.size() != 0) begin
      errors++; $display("[TB] FAIL flush_hold: writes=%0d before flush, required 0", wrQ.size());
    end
    DOWNLOADING = 1'b0;
    waitWrites(1);
    repeat (4) tick;
    checks++;
    if (wrQ.size() != 1 || wrQ[0].addr !== 22'h2 || wrQ[0].data[7:0] !== 8'hAB ||
        wrQ[0].mask !== 2'b10 || wrQ[0].ba !== 2'd2) begin
      errors++;
      $display("[TB] FAIL flush_write: count=%0d first=%h, required one write addr=2 data[7:0]=ab mask=10 ba=2",
               wrQ.size(), wrQ.size() > 0 ? wrQ[0] : wr_t'('0));
    end
    DOWNLOADING = 1'b1;
    tick;
  endtask

  task automatic test_unmerged;
    wrQ.delete();
    sendByte(23'h010, 2'd0, 8'h55);
    sendByte(23'h020, 2'd0, 8'h66);
    waitWrites(1);
    repeat (4) tick;
    checks++;
    if (wrQ.size() != 1 || wrQ[0] !== wr_t'{22'h8, 16'h5500, 2'b01, 2'd0}) begin
      errors++;
      $display("[TB] FAIL unmerged_first: count=%0d first=%h, required count=1 %h", wrQ.size(),
               wrQ.size() > 0 ? wrQ[0] : wr_t'('0), wr_t'{22'h8, 16'h5500, 2'b01, 2'd0});
    end
    DOWNLOADING = 1'b0;
    waitWrites(2);
    checks++;
    if (wrQ.size() != 2 || wrQ[1] !== wr_t'{22'h10, 16'h6600, 2'b01, 2'd0}) begin
      errors++;
      $display("[TB] FAIL unmerged_second: count=%0d second=%h, required %h", wrQ.size(),
               wrQ.size() > 1 ? wrQ[1] : wr_t'('0), wr_t'{22'h10, 16'h6600, 2'b01, 2'd0});
    end
    DOWNLOADING = 1'b1;
    tick;
  endtask

  task automatic test_back_pressure;
    wrQ.delete();
    PROG_RDY = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sendByte(23'(23'h200 + 2*i),     2'd1, 8'(8'h10 + i));
      sendByte(23'(23'h200 + 2*i + 1), 2'd1, 8'(8'h80 + i));
    end
    repeat (2) tick;
    checks++;
    if (WAIT !== 1'b0) begin
      errors++; $display("[TB] FAIL wait_at_6: WAIT=%b, required 0", WAIT);
    end
    sendByte(23'h20C, 2'd1, 8'h16);
    sendByte(23'h20D, 2'd1, 8'h86);
    repeat (2) tick;
    checks++;
    if (WAIT !== 1'b1) begin
      errors++; $display("[TB] FAIL wait_at_7: WAIT=%b, required 1", WAIT);
    end
    checks++;
    if (PROG_WE !== 1'b1 || PROG_ADDR !== 22'h100) begin
      errors++;
      $display("[TB] FAIL stall_hold: WE=%b ADDR=%h, required WE=1 ADDR=100", PROG_WE, PROG_ADDR);
    end
    IN_WE = 1'b1; IN_ADDR = 23'h7FE; IN_BA = 2'd1; IN_DATA = 8'hEE;
    tick;
    IN_WE = 1'b0;
    PROG_RDY = 1'b1;
    for (int i = 7; i < 16; i++) begin
      sendByte(23'(23'h200 + 2*i),     2'd1, 8'(8'h10 + i));
      sendByte(23'(23'h200 + 2*i + 1), 2'd1, 8'(8'h80 + i));
    end
    waitWrites(16);
    repeat (8) tick;
    checks++;
    if (wrQ.size() != 16) begin
      errors++; $display("[TB] FAIL drain_count: writes=%0d, required 16", wrQ.size());
    end
    for (int i = 0; i < 16 && i < wrQ.size(); i++) begin
      checks++;
      if (wrQ[i] !== wr_t'{22'(22'h100 + i), {8'(8'h10 + i), 8'(8'h80 + i)}, 2'b00, 2'd1}) begin
        errors++;
        $display("[TB] FAIL drain_order[%0d]: got %h, required %h", i, wrQ[i],
                 wr_t'{22'(22'h100 + i), {8'(8'h10 + i), 8'(8'h80 + i)}, 2'b00, 2'd1});
      end
    end
  endtask

  task automatic test_rdy_hold;
    wrQ.delete();
    PROG_RDY = 1'b0;
    sendByte(23'h040, 2'd3, 8'hA1);
    sendByte(23'h041, 2'd3, 8'hA2);
    sendByte(23'h042, 2'd3, 8'hB1);
    sendByte(23'h043, 2'd3, 8'hB2);
    waitWe("rdy_first_we");
    PROG_RDY = 1'b1;
    tick;
    checks++;
    if (PROG_WE !== 1'b0) begin
      errors++; $display("[TB] FAIL rdy_gap1: PROG_WE=%b, required 0", PROG_WE);
    end
    tick;
    checks++;
    if (PROG_WE !== 1'b0) begin
      errors++; $display("[TB] FAIL rdy_gap2: PROG_WE=%b, required 0", PROG_WE);
    end
    tick;
    PROG_RDY = 1'b0;
    checks++;
    if (PROG_WE !== 1'b1 || PROG_ADDR !== 22'h21) begin
      errors++;
      $display("[TB] FAIL rdy_next: WE=%b ADDR=%h, required WE=1 ADDR=21", PROG_WE, PROG_ADDR);
    end
    repeat (3) tick;
    checks++;
    if (wrQ.size() != 1) begin
      errors++; $display("[TB] FAIL rdy_single_pop: writes=%0d, required 1", wrQ.size());
    end
    PROG_RDY = 1'b1;
    waitWrites(2);
    repeat (4) tick;
    checks++;
    if (wrQ.size() != 2 || wrQ[0] !== wr_t'{22'h20, 16'hA1A2, 2'b00, 2'd3} ||
        wrQ[1] !== wr_t'{22'h21, 16'hB1B2, 2'b00, 2'd3}) begin
      errors++;
      $display("[TB] FAIL rdy_writes: count=%0d first=%h, required count=2 %h then %h", wrQ.size(),
               wrQ.size() > 0 ? wrQ[0] : wr_t'('0), wr_t'{22'h20, 16'hA1A2, 2'b00, 2'd3},
               wr_t'{22'h21, 16'hB1B2, 2'b00, 2'd3});
    end
  endtask

  task automatic test_reset_midwrite;
    wrQ.delete();
    PROG_RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sendByte(23'(23'h300 + 2*i),     2'd0, 8'(8'hC0 + i));
      sendByte(23'(23'h300 + 2*i + 1), 2'd0, 8'(8'hD0 + i));
    end
    waitWe("midwrite_we");
    repeat (3) tick;
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if (PROG_WE !== 1'b0 || WAIT !== 1'b0 || PROG_ADDR !== 22'h0) begin
      errors++;
      $display("[TB] FAIL async_reset: WE=%b WAIT=%b ADDR=%h, required all 0", PROG_WE, WAIT, PROG_ADDR);
    end
    tick;
    RESET_N = 1'b1;
    PROG_RDY = 1'b1;
    repeat (12) tick;
    checks++;
    if (wrQ.size() != 0 || PROG_WE !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_abandon: writes=%0d WE=%b, required 0 writes WE=0", wrQ.size(), PROG_WE);
    end
  endtask

`ifdef BATRIDER_WRBUF_CHKSUM_EN
  task automatic test_chksum;
    wrQ.delete();
    PROG_RDY = 1'b1;
    DOWNLOADING = 1'b0;
    tick;
    DOWNLOADING = 1'b1;
    tick;
    sendByte(23'h100, 2'd0, 8'hFF);
    sendByte(23'h101, 2'd0, 8'h02);
    checks++;
    if (CHKSUM !== 16'h0101) begin
      errors++; $display("[TB] FAIL chksum: CHKSUM=%h, required 0101", CHKSUM);
    end
    waitWrites(1);
    repeat (3) tick;
    checks++;
    if (WR_COUNT !== 24'd1) begin
      errors++; $display("[TB] FAIL wr_count: WR_COUNT=%0d, required 1", WR_COUNT);
    end
  endtask
`endif

  initial begin
    RESET_N = 1'b0; DOWNLOADING = 1'b1; IN_WE = 1'b0;
    IN_ADDR = '0; IN_BA = '0; IN_DATA = '0; PROG_RDY = 1'b0;
    repeat (3) tick;
    test_reset;
    RESET_N = 1'b1;
    repeat (2) tick;
    test_merge;
    test_flush;
    test_unmerged;
    test_back_pressure;
    test_rdy_hold;
    test_reset_midwrite;
`ifdef BATRIDER_WRBUF_CHKSUM_EN
    test_chksum;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/batrider_prog_wrbuf.md
Name: batrider_prog_wrbuf

Overview:
- Download write buffer between the ioctl byte stream and the SDRAM programming port of the batrider SDRAM mapper.
- Merges byte pairs that fall in the same 16-bit word (even byte, then odd byte) into one masked word write, so the write count is halved.
- Queues words in a small FIFO and drives PROG_WE with a full PROG_RDY handshake.
- Raises WAIT toward the downloader when the FIFO cannot accept more data.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- AW, 22, SDRAM word-address width.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- DOWNLOADING  in  1  download active; its falling edge flushes any pending half-word.
- IN_WE  in  1  one-cycle byte strobe; ignored while WAIT=1.
- IN_ADDR  in  AW+1  byte address within bank; word = IN_ADDR>>1.
- IN_BA  in  2  target SDRAM bank.
- IN_DATA  in  8  byte data.
- WAIT  out  1  stall request to the downloader.
- PROG_ADDR  out  AW  word address.
- PROG_DATA  out  16  write data.
- PROG_MASK  out  2  DQM; a set bit means that byte is NOT written.
- PROG_BA  out  2  bank.
- PROG_WE  out  1  write request, held until PROG_RDY.
- PROG_RDY  in  1  SDRAM write complete.

Behaviour:
- Reset (async, RESET_N=0): all outputs 0, FIFO empty, pending register invalid, output FSM in IDLE. Reset mid-write abandons that write; PROG_WE drops immediately.
- Lane mapping:
  - Even byte → PROG_DATA[15:8], mask 01.
  - Odd byte → PROG_DATA[7:0], mask 10.
  - Merged word → mask 00.
- Pending register holds {addr, ba, data, mask, valid}.
- Accepting a byte (IN_WE=1, WAIT=0):
  - Pending invalid: load the byte, valid=1.
  - Pending valid, same word and bank, complementary lane: merge, push the word to the FIFO, valid=0.
  - Any other case: push the pending entry unmerged, then load the new byte.
- Pushes happen in the cycle after the strobe. WAIT = FIFO count ≥ DEPTH-1, so one push slot is always reserved.
- Flush: on the DOWNLOADING 1→0 edge, a valid pending entry is pushed unmerged. If the FIFO is full, the flush waits (WAIT stays 1) until a slot frees.
- Output FSM:
  - IDLE: FIFO non-empty → latch the head onto PROG_*, PROG_WE=1, go to WRITE.
  - WRITE: hold PROG_* stable until PROG_RDY=1, then pop, PROG_WE=0, go to GAP.
  - GAP: one cycle with PROG_WE=0 (absorbs a multi-cycle RDY), then go to IDLE.
- Latency: the first byte of a pair arriving at cycle t with the FIFO empty gives PROG_WE=1 at t+3 after the pair completes (push t+1, latch t+2, WE t+3).
- A simultaneous push and pop keeps the count unchanged. The FIFO index pointers are log2(DEPTH)+1 bits and wrap naturally.
- PROG_RDY outside WRITE is ignored.
- Word-address wrap at 2^AW is not special-cased.

Optional Feature:
- BATRIDER_WRBUF_CHKSUM_EN.
- Defined:
  - Adds output CHKSUM [15:0], the modulo-2^16 sum of every byte accepted since the last DOWNLOADING 0→1 edge; cleared on that edge and on reset.
  - Adds output WR_COUNT [23:0], the number of PROG_RDY completions, cleared at the same points.
- Undefined: neither port exists, no added logic.

Decomposition:
- Package batrider_wrbuf_pkg holds:
  - the output FSM state enum (IDLE, WRITE, GAP);
  - the mask constants MASK_HI=2'b01, MASK_LO=2'b10, MASK_BOTH=2'b00;
  - the FIFO entry struct {addr, ba, data, mask}.
- Sub-module batrider_wrbuf_fifo: synchronous FIFO with push/pop/count/full/empty and async active-low reset.
- Merge logic and the output FSM stay in the top module.

Test Plan:
- Bytes 0x12 @0x000, then 0x34 @0x001, bank 0, PROG_RDY tied 1 → exactly one write: ADDR 0, DATA 0x1234, MASK 00, BA 0.
- Lone byte 0xAB @0x005 bank 2, then DOWNLOADING falls → one write: ADDR 2, DATA[7:0]=0xAB, MASK 10, BA 2.
- Bytes @0x010 then @0x020 → two unmerged writes: ADDR 8 with MASK 01, then ADDR 0x10 with MASK 01.
- PROG_RDY held 0, 16 paired bytes streamed with DEPTH=8:
  - WAIT asserts when count reaches 7; no strobe accepted while WAIT=1.
  - Releasing RDY drains the writes in order with no data lost.
- PROG_RDY high for 3 cycles on one write → single pop; PROG_WE low for at least 1 cycle before the next write.
- RESET_N pulsed low in WRITE with 3 queued writes → PROG_WE=0 asynchronously and FIFO empty. With CHKSUM_EN: after bytes 0xFF, 0x02 → CHKSUM=0x0101.
